// File: rtl/pc_sequencer.sv
// Next-PC controller: arbitrates exception/eret/branch redirects, holds through
// stalls and imem wait states with a one-entry pending redirect, and keeps statistics.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      pc,
  input  logic             stall,
  input  logic             imem_ready,
  input  logic             br_valid,
  input  logic [31:0]      br_target,
  input  logic             eret,
  input  logic [31:0]      epc,
  input  logic             exc_req,
  input  logic             halt_req,
  output logic             pc_en,
  output logic             pc_jump,
  output logic [31:0]      pc_target,
  output logic             halted,
  output logic             target_misaligned,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] redirect_cnt
);

  typedef enum logic {RUN, HALT} state_t;
  // Redirect priorities; a pending entry remembers the level it was loaded at.
  typedef enum logic [1:0] {PRI_BR = 2'd0, PRI_ERET = 2'd1, PRI_EXC = 2'd2} prio_t;

  state_t      state, state_next;
  logic        pend_valid, pend_valid_next;
  logic [31:0] pend_target, pend_target_next;
  prio_t       pend_prio, pend_prio_next;

  logic        run, halt_go, adv;
  logic        src_valid;
  prio_t       src_prio;
  logic [31:0] src_target;
  logic        win_valid;
  logic [31:0] win_target;

  // Live source selection
  always_comb begin
    src_valid  = 1'b0;
    src_prio   = PRI_BR;
    src_target = br_target;
    if (exc_req) begin
      src_valid  = 1'b1;
      src_prio   = PRI_EXC;
      src_target = EXC_VECTOR;
    end else if (eret) begin
      src_valid  = 1'b1;
      src_prio   = PRI_ERET;
      src_target = epc;
    end else if (br_valid) begin
      src_valid  = 1'b1;
      src_prio   = PRI_BR;
      src_target = br_target;
    end
  end

  always_comb begin
    run     = (state == RUN) && !reset;
    halt_go = run && halt_req && !exc_req;
    adv     = run && !halt_go && !stall && imem_ready;

    // Equal priority: the live source wins, matching the overwrite rule.
    win_valid  = src_valid || pend_valid;
    win_target = src_target;
    if (pend_valid && (!src_valid || (pend_prio > src_prio)))
      win_target = pend_target;

    pc_en     = adv;
    pc_jump   = adv && win_valid;
    pc_target = win_valid ? win_target : pc + 32'd4;
    halted    = (state == HALT);

    state_next       = state;
    pend_valid_next  = pend_valid;
    pend_target_next = pend_target;
    pend_prio_next   = pend_prio;
    if (halt_go) begin
      state_next      = HALT;
      pend_valid_next = 1'b0;
    end else if (run) begin
      if (adv) begin
        pend_valid_next = 1'b0;
      end else if (src_valid && (!pend_valid || (src_prio >= pend_prio))) begin
        pend_valid_next  = 1'b1;
        pend_target_next = src_target;
        pend_prio_next   = src_prio;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= RUN;
      pend_valid        <= 1'b0;
      pend_target       <= '0;
      pend_prio         <= PRI_BR;
      target_misaligned <= 1'b0;
      stall_cnt         <= '0;
      redirect_cnt      <= '0;
    end else begin
      state       <= state_next;
      pend_valid  <= pend_valid_next;
      pend_target <= pend_target_next;
      pend_prio   <= pend_prio_next;
      if (pc_jump && (pc_target[1:0] != 2'b00))
        target_misaligned <= 1'b1;
      if (run && !adv && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
      if (pc_jump && (redirect_cnt != '1))
        redirect_cnt <= redirect_cnt + 1'b1;
    end
  end

endmodule
